// File: rtl/vibe_motor_driver.sv
// Vibration motor driver: trigger edge -> fixed full-strength burst + cooldown, else acc-level PWM rumble.
// Latency: one cycle from trigger edge to o_state/o_motor_n; no backpressure (free-running outputs).
module vibe_motor_driver #(
  parameter int TICK_DIV    = 108000,
  parameter int BURST_MS    = 200,
  parameter int COOLDOWN_MS = 100,
  parameter int PWM_DIV     = 1080,
  parameter int ACC_THRESH  = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_trigger,
  input  logic [2:0] i_acc_level,
  output logic       o_motor_n,
  output logic       o_active,
  output logic [1:0] o_state
);

  localparam int DUR_MAX = (BURST_MS > COOLDOWN_MS) ? BURST_MS : COOLDOWN_MS;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t              state;
  logic                trig_prev;
  logic [DUR_W-1:0]    dur_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [2:0]          phase;
  logic                trig_edge;
  logic                tick;
  logic                rumble_on;

  assign trig_edge = i_trigger & ~trig_prev;
  assign tick      = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign rumble_on = (int'(i_acc_level) > ACC_THRESH) && (phase < i_acc_level);
  assign o_state   = state;
  assign o_active  = ~o_motor_n;

  always_ff @(posedge i_clk) begin
    // History follows the pin even in reset/disable so a level held across release never fires.
    trig_prev <= i_trigger;

    if (i_rst || !i_enable) begin
      state     <= IDLE;
      dur_cnt   <= '0;
      pre_cnt   <= '0;
      step_cnt  <= '0;
      phase     <= '0;
      o_motor_n <= 1'b1;
    end else begin
      if (step_cnt == STEP_W'(PWM_DIV - 1)) begin
        step_cnt <= '0;
        phase    <= phase + 3'd1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          pre_cnt <= '0;
          if (trig_edge) begin
            state     <= BURST;
            dur_cnt   <= DUR_W'(BURST_MS);
            o_motor_n <= 1'b0;
          end else begin
            o_motor_n <= ~rumble_on;
          end
        end

        BURST: begin
          if (trig_edge) begin
            // Retrigger beats a coincident final tick.
            dur_cnt   <= DUR_W'(BURST_MS);
            pre_cnt   <= '0;
            o_motor_n <= 1'b0;
          end else if (tick) begin
            pre_cnt <= '0;
            if (dur_cnt == DUR_W'(1)) begin
              state     <= COOLDOWN;
              dur_cnt   <= DUR_W'(COOLDOWN_MS);
              o_motor_n <= 1'b1;
            end else begin
              dur_cnt   <= dur_cnt - 1'b1;
              o_motor_n <= 1'b0;
            end
          end else begin
            pre_cnt   <= pre_cnt + 1'b1;
            o_motor_n <= 1'b0;
          end
        end

        COOLDOWN: begin
          if (tick) begin
            pre_cnt <= '0;
            if (dur_cnt == DUR_W'(1)) begin
              state     <= IDLE;
              dur_cnt   <= '0;
              o_motor_n <= ~rumble_on;
            end else begin
              dur_cnt   <= dur_cnt - 1'b1;
              o_motor_n <= 1'b1;
            end
          end else begin
            pre_cnt   <= pre_cnt + 1'b1;
            o_motor_n <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          dur_cnt   <= '0;
          pre_cnt   <= '0;
          o_motor_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vibe_motor_driver.sv
// Bench for vibe_motor_driver: cycle-count reference model compared every cycle, plus directed literal checks.
module tb_vibe_motor_driver;

  localparam int TICK_DIV    = 10;
  localparam int BURST_MS    = 5;
  localparam int COOLDOWN_MS = 3;
  localparam int PWM_DIV     = 2;
  localparam int ACC_THRESH  = 5;
  localparam int BURST_CYC   = BURST_MS * TICK_DIV;
  localparam int COOL_CYC    = COOLDOWN_MS * TICK_DIV;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic       i_trigger;
  logic [2:0] i_acc_level;
  logic       o_motor_n;
  logic       o_active;
  logic [1:0] o_state;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Reference model: state plus remaining cycles, PWM phase from elapsed enabled cycles.
  int m_state = 0;
  int m_left  = 0;
  int m_pwm_t = 0;
  bit m_on    = 1'b0;
  bit m_prev  = 1'b0;

  vibe_motor_driver #(
    .TICK_DIV(TICK_DIV), .BURST_MS(BURST_MS), .COOLDOWN_MS(COOLDOWN_MS),
    .PWM_DIV(PWM_DIV), .ACC_THRESH(ACC_THRESH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_trigger(i_trigger),
    .i_acc_level(i_acc_level), .o_motor_n(o_motor_n), .o_active(o_active), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin : model
    bit rise;
    int phase;
    rise   = i_trigger && !m_prev;
    m_prev = i_trigger;
    if (i_rst || !i_enable) begin
      m_state = 0;
      m_left  = 0;
      m_pwm_t = 0;
      m_on    = 1'b0;
    end else begin
      phase   = (m_pwm_t / PWM_DIV) % 8;
      m_pwm_t = m_pwm_t + 1;
      case (m_state)
        0: if (rise) begin m_state = 1; m_left = BURST_CYC; end
        1: begin
          if (rise) m_left = BURST_CYC;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_state = 2; m_left = COOL_CYC; end
          end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == 0) m_state = 0;
        end
      endcase
      m_on = (m_state == 1) ||
             (m_state == 0 && int'(i_acc_level) > ACC_THRESH && phase < int'(i_acc_level));
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      checks++;
      if (o_state !== 2'(m_state) || o_motor_n !== !m_on || o_active !== m_on) begin
        failures++;
        $display("FAIL model t=%0t state=%0d exp=%0d motor_n=%b exp=%b active=%b exp=%b",
                 $time, o_state, m_state, o_motor_n, !m_on, o_active, m_on);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic run_len(input int st, output int n);
    n = 0;
    while (int'(o_state) == st && n < 1000) begin
      n++;
      @(negedge i_clk);
    end
  endtask

  task automatic count_on(input int n, output int on);
    on = 0;
    repeat (n) begin
      if (o_motor_n == 1'b0) on++;
      @(negedge i_clk);
    end
  endtask

  initial begin
    int n, nb, nc, ent, prev_st;
    i_rst = 1'b1; i_enable = 1'b1; i_trigger = 1'b0; i_acc_level = 3'd0;
    @(posedge i_clk);
    chk_on = 1'b1;
    @(negedge i_clk);
    check("reset_state", o_state, 0);
    check("reset_motor_n", o_motor_n, 1);
    cyc(2);
    i_rst = 1'b0;

    nb = 0; n = 0;
    repeat (200) begin
      if (o_motor_n == 1'b0) n++;
      if (o_state != 2'd0) nb++;
      @(negedge i_clk);
    end
    check("quiet_motor_on", n, 0);
    check("quiet_not_idle", nb, 0);

    i_trigger = 1'b1; cyc(1); i_trigger = 1'b0;
    run_len(1, n); check("burst_len", n, BURST_CYC);
    run_len(2, n); check("cool_len", n, COOL_CYC);
    check("idle_after_cool", o_state, 0);
    cyc(5);

    i_trigger = 1'b1; cyc(1); i_trigger = 1'b0;
    cyc(29);
    i_trigger = 1'b1; cyc(1); i_trigger = 1'b0;
    run_len(1, n); check("retrig_burst_len", n, BURST_CYC);
    n = 0;
    while (o_state == 2'd2 && n < 1000) begin
      if (n == 10) i_trigger = 1'b1;
      if (n == 11) i_trigger = 1'b0;
      n++;
      @(negedge i_clk);
    end
    check("lockout_cool_len", n, COOL_CYC);
    check("lockout_idle", o_state, 0);
    cyc(10);
    check("lockout_still_idle", o_state, 0);

    i_acc_level = 3'd7; cyc(3); count_on(16, n); check("rumble_acc7", n, 14);
    i_acc_level = 3'd6; cyc(3); count_on(16, n); check("rumble_acc6", n, 12);
    i_acc_level = 3'd5; cyc(3); count_on(32, n); check("rumble_acc5", n, 0);

    i_trigger = 1'b1; nb = 0; nc = 0; ent = 0; prev_st = 0;
    repeat (200) begin
      cyc(1);
      if (o_state == 2'd1) nb++;
      if (o_state == 2'd2) nc++;
      if (o_state == 2'd1 && prev_st != 1) ent++;
      prev_st = int'(o_state);
    end
    check("held_burst_cycles", nb, BURST_CYC);
    check("held_cool_cycles", nc, COOL_CYC);
    check("held_burst_count", ent, 1);
    check("held_final_idle", o_state, 0);

    i_trigger = 1'b0; cyc(3); i_trigger = 1'b1; cyc(1);
    check("rearm_burst", o_state, 1);
    cyc(19);
    i_enable = 1'b0; cyc(1);
    check("disable_state", o_state, 0);
    check("disable_motor_n", o_motor_n, 1);
    cyc(3); i_enable = 1'b1; cyc(10);
    check("reenable_no_fire", o_state, 0);

    i_trigger = 1'b0; cyc(1); i_trigger = 1'b1; cyc(15);
    check("burst_before_rst", o_state, 1);
    i_rst = 1'b1; cyc(1);
    check("rst_state", o_state, 0);
    check("rst_motor_n", o_motor_n, 1);
    cyc(1); i_rst = 1'b0;
    nb = 0;
    repeat (20) begin
      if (o_state != 2'd0) nb++;
      @(negedge i_clk);
    end
    check("rst_release_no_fire", nb, 0);

    i_trigger = 1'b0; cyc(2);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 29) == 0) i_trigger = !i_trigger;
      if ($urandom_range(0, 39) == 0) i_acc_level = 3'($urandom_range(0, 7));
      i_enable = ($urandom_range(0, 199) != 0);
      i_rst    = ($urandom_range(0, 999) == 0);
      cyc(1);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
